ddr3_pg_xfer_arb: RTL and testbench

//  N-channel arbiter/multiplexer for DDR3 page-transfer requests, in the DDR3 ui clock domain.

---
 rtl/ddr3_pg_xfer_arb.sv | 173 +++++++++++++++++
 tb/tb_ddr3_pg_xfer_arb.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_pg_xfer_arb.sv
// N-channel arbiter/mux onto the single DDR3 page-transfer port (ui clock domain).
// Grants one channel at a time, steers ack/read-wren back to it, and flags ack timeouts.
module ddr3_pg_xfer_arb #(
    parameter int N_CH        = 4,
    parameter int ADDR_W      = 28,
    parameter int DATA_W      = 128,
    parameter int ARB_MODE    = 0,
    parameter int SYNC_REQ    = 1,
    parameter int TIMEOUT_CYC = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_CH-1:0]           ch_pg_req,
    input  logic [N_CH-1:0]           ch_pg_optype,
    input  logic [N_CH*ADDR_W-1:0]    ch_pg_req_addr,
    input  logic [N_CH*DATA_W-1:0]    ch_dpram_dout,
    output logic [N_CH-1:0]           ch_pg_ack,
    output logic [N_CH-1:0]           ch_dpram_wren,
    output logic                      ddr3_pg_req,
    output logic                      ddr3_pg_optype,
    output logic [ADDR_W-1:0]         ddr3_pg_req_addr,
    output logic [DATA_W-1:0]         ddr3_dpram_dout,
    input  logic                      ddr3_pg_ack,
    input  logic                      ddr3_dpram_wren,
    output logic [$clog2(N_CH)-1:0]   grant_idx,
    output logic                      busy,
    output logic                      ack_timeout,
    output logic [1:0]                fsm_state
);

    localparam int          GW     = $clog2(N_CH);
    localparam logic [15:0] TO_VAL = 16'(TIMEOUT_CYC);
    localparam bit          TO_EN  = (TIMEOUT_CYC != 0);

    // Handshake: a channel holds ch_pg_req high until it sees its ch_pg_ack pulse;
    // the arbiter holds ddr3_pg_req until ddr3_pg_ack, then waits for the granted
    // channel to drop its request before returning to idle.
    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_PG_REQ     = 2'd1,
        S_CLEAR_WAIT = 2'd2
    } state_t;

    state_t            state;
    logic [GW-1:0]     last_grant;
    logic [15:0]       to_cnt;
    logic [N_CH-1:0]   req_s;
    logic [N_CH-1:0]   grant_sel;
    logic [GW-1:0]     rr_win;
    logic [GW-1:0]     rr_cand;
    logic              rr_hit;
    logic [GW-1:0]     fp_win;
    logic [GW-1:0]     win;

    generate
        if (SYNC_REQ != 0) begin : g_sync
            logic [N_CH-1:0] req_meta;
            logic [N_CH-1:0] req_stab;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    req_meta <= '0;
                    req_stab <= '0;
                end else begin
                    req_meta <= ch_pg_req;
                    req_stab <= req_meta;
                end
            end
            assign req_s = req_stab;
        end else begin : g_nosync
            assign req_s = ch_pg_req;
        end
    endgenerate

    assign busy      = (state != S_IDLE);
    assign fsm_state = state;

    // Out-of-range grant_idx matches no channel, so the mux falls back to zero.
    always_comb begin
        ddr3_pg_optype   = 1'b0;
        ddr3_pg_req_addr = '0;
        ddr3_dpram_dout  = '0;
        grant_sel        = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (grant_idx == GW'(i)) begin
                ddr3_pg_optype   = ch_pg_optype[i];
                ddr3_pg_req_addr = ch_pg_req_addr[i*ADDR_W +: ADDR_W];
                ddr3_dpram_dout  = ch_dpram_dout[i*DATA_W +: DATA_W];
                grant_sel[i]     = busy;
            end
        end
    end

    assign ch_dpram_wren = grant_sel & {N_CH{ddr3_dpram_wren}};

    always_comb begin
        rr_win  = '0;
        rr_hit  = 1'b0;
        rr_cand = '0;
        for (int k = 1; k <= N_CH; k++) begin
            rr_cand = GW'((int'(last_grant) + k) % N_CH);
            if (!rr_hit && req_s[rr_cand]) begin
                rr_hit = 1'b1;
                rr_win = rr_cand;
            end
        end
    end

    always_comb begin
        fp_win = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (req_s[i]) begin
                fp_win = GW'(i);
            end
        end
    end

    assign win = (ARB_MODE == 1) ? fp_win : rr_win;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_pg_ack <= '0;
        end else begin
            ch_pg_ack <= grant_sel & {N_CH{ddr3_pg_ack}};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            ddr3_pg_req <= 1'b0;
            grant_idx   <= '0;
            last_grant  <= GW'(N_CH - 1);
            to_cnt      <= '0;
            ack_timeout <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (|req_s) begin
                        grant_idx   <= win;
                        ddr3_pg_req <= 1'b1;
                        to_cnt      <= '0;
                        state       <= S_PG_REQ;
                    end
                end
                S_PG_REQ: begin
                    ddr3_pg_req <= 1'b1;
                    if (to_cnt != 16'hFFFF) begin
                        to_cnt <= to_cnt + 16'd1;
                    end
                    // Timeout only reports; the transfer keeps waiting for its ack.
                    if (TO_EN && (to_cnt == TO_VAL)) begin
                        ack_timeout <= 1'b1;
                    end
                    if (ddr3_pg_ack) begin
                        state <= S_CLEAR_WAIT;
                    end
                end
                S_CLEAR_WAIT: begin
                    ddr3_pg_req <= req_s[grant_idx];
                    if (!req_s[grant_idx] && !ddr3_pg_req && !ddr3_pg_ack) begin
                        last_grant <= grant_idx;
                        state      <= S_IDLE;
                    end
                end
                default: begin
                    ddr3_pg_req <= 1'b0;
                    state       <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ddr3_pg_xfer_arb.sv
// Directed bench for ddr3_pg_xfer_arb: round-robin/timeout instance plus a fixed-priority,
// unsynchronised instance; grants are scoreboarded against an expected-channel queue.
module tb_ddr3_pg_xfer_arb;

    localparam int N_CH   = 4;
    localparam int ADDR_W = 28;
    localparam int DATA_W = 128;
    localparam int GW     = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- DUT signals ----------------
    logic [N_CH-1:0]        req = '0;
    logic [N_CH-1:0]        optype = '0;
    logic [N_CH*ADDR_W-1:0] addr_bus = '0;
    logic [N_CH*DATA_W-1:0] dout_bus = '0;
    logic                   ddr3_pg_ack = 1'b0;
    logic                   ddr3_dpram_wren = 1'b0;
    logic [N_CH-1:0]        ch_pg_ack;
    logic [N_CH-1:0]        ch_dpram_wren;
    logic                   ddr3_pg_req;
    logic                   ddr3_pg_optype;
    logic [ADDR_W-1:0]      ddr3_pg_req_addr;
    logic [DATA_W-1:0]      ddr3_dpram_dout;
    logic [GW-1:0]          grant_idx;
    logic                   busy;
    logic                   ack_timeout;
    logic [1:0]             fsm_state;

    logic [N_CH-1:0]        fp_req = '0;
    logic                   fp_ack = 1'b0;
    logic                   fp_wren = 1'b0;
    logic [N_CH-1:0]        fp_ch_ack;
    logic [N_CH-1:0]        fp_ch_wren;
    logic                   fp_pg_req;
    logic                   fp_optype;
    logic [ADDR_W-1:0]      fp_addr;
    logic [DATA_W-1:0]      fp_dout;
    logic [GW-1:0]          fp_grant;
    logic                   fp_busy;
    logic                   fp_timeout;
    logic [1:0]             fp_state;

    ddr3_pg_xfer_arb #(
        .N_CH(N_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .ARB_MODE(0), .SYNC_REQ(1), .TIMEOUT_CYC(10)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .ch_pg_req(req), .ch_pg_optype(optype),
        .ch_pg_req_addr(addr_bus), .ch_dpram_dout(dout_bus),
        .ch_pg_ack(ch_pg_ack), .ch_dpram_wren(ch_dpram_wren),
        .ddr3_pg_req(ddr3_pg_req), .ddr3_pg_optype(ddr3_pg_optype),
        .ddr3_pg_req_addr(ddr3_pg_req_addr), .ddr3_dpram_dout(ddr3_dpram_dout),
        .ddr3_pg_ack(ddr3_pg_ack), .ddr3_dpram_wren(ddr3_dpram_wren),
        .grant_idx(grant_idx), .busy(busy), .ack_timeout(ack_timeout),
        .fsm_state(fsm_state)
    );

    ddr3_pg_xfer_arb #(
        .N_CH(N_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .ARB_MODE(1), .SYNC_REQ(0), .TIMEOUT_CYC(0)
    ) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .ch_pg_req(fp_req), .ch_pg_optype(optype),
        .ch_pg_req_addr(addr_bus), .ch_dpram_dout(dout_bus),
        .ch_pg_ack(fp_ch_ack), .ch_dpram_wren(fp_ch_wren),
        .ddr3_pg_req(fp_pg_req), .ddr3_pg_optype(fp_optype),
        .ddr3_pg_req_addr(fp_addr), .ddr3_dpram_dout(fp_dout),
        .ddr3_pg_ack(fp_ack), .ddr3_dpram_wren(fp_wren),
        .grant_idx(fp_grant), .busy(fp_busy), .ack_timeout(fp_timeout),
        .fsm_state(fp_state)
    );

    // ---------------- scoreboard ----------------
    logic [GW-1:0]     exp_q[$];
    logic [ADDR_W-1:0] ch_addr[N_CH];
    logic [DATA_W-1:0] ch_data[N_CH];
    logic              ch_op[N_CH];
    int                grants[N_CH];
    int                n_checks = 0;
    int                n_errors = 0;

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N_CH-1:0] onehot(input logic [GW-1:0] c);
        logic [N_CH-1:0] v;
        v = '0;
        v[c] = 1'b1;
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_req(output int lat);
        lat = 0;
        while (ddr3_pg_req !== 1'b1 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        chk("req_rise_bound", ddr3_pg_req, 1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("idle_bound", busy, 0);
    endtask

    task automatic grant_phase(output logic [GW-1:0] e, output int lat);
        e = exp_q.pop_front();
        wait_req(lat);
        chk("grant_idx", grant_idx, e);
        chk("mux_addr", ddr3_pg_req_addr, ch_addr[e]);
        chk("mux_dout", ddr3_dpram_dout, ch_data[e]);
        chk("mux_optype", ddr3_pg_optype, ch_op[e]);
        grants[e]++;
    endtask

    task automatic finish_phase(input logic [GW-1:0] e, input bit rearm);
        ddr3_pg_ack = 1'b1;
        @(negedge clk);
        ddr3_pg_ack = 1'b0;
        chk("ch_pg_ack", ch_pg_ack, onehot(e));
        req[e] = 1'b0;
        @(negedge clk);
        chk("ch_pg_ack_pulse", ch_pg_ack, 0);
        wait_idle();
        if (rearm) req[e] = 1'b1;
    endtask

    task automatic do_xfer(input int ack_dly, input bit rearm, output int lat);
        logic [GW-1:0] e;
        grant_phase(e, lat);
        cyc(ack_dly);
        chk("busy_in_xfer", busy, 1);
        finish_phase(e, rearm);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int lat;
        int cnt;
        logic [GW-1:0] e;

        for (int i = 0; i < N_CH; i++) begin
            ch_addr[i] = ADDR_W'($urandom_range(0, 32'h0FFF_FFFF));
            ch_data[i] = {$urandom, $urandom, $urandom, $urandom};
            ch_op[i]   = 1'($urandom_range(0, 1));
            addr_bus[i*ADDR_W +: ADDR_W] = ch_addr[i];
            dout_bus[i*DATA_W +: DATA_W] = ch_data[i];
            optype[i] = ch_op[i];
            grants[i] = 0;
        end

        // reset values
        cyc(3);
        chk("rst_pg_req", ddr3_pg_req, 0);
        chk("rst_ch_ack", ch_pg_ack, 0);
        chk("rst_grant", grant_idx, 0);
        chk("rst_busy", busy, 0);
        chk("rst_timeout", ack_timeout, 0);
        chk("rst_state", fsm_state, 0);
        rst_n = 1'b1;
        cyc(2);

        // round-robin fairness with all four channels held
        exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        req = 4'hF;
        for (int t = 0; t < 8; t++) do_xfer(2, 1'b1, lat);
        for (int i = 0; i < N_CH; i++) chk("rr_share", grants[i], 2);
        // the synchroniser still shows requests, so one more grant (ch0) drains the queue
        req = 4'h0;
        do_xfer(2, 1'b0, lat);
        cyc(4);
        chk("rr_drained_idle", busy, 0);
        chk("rr_drained_q", exp_q.size(), 0);

        // single request on ch2, ack five cycles after the grant
        exp_q.push_back(2'd2);
        req[2] = 1'b1;
        do_xfer(5, 1'b0, lat);
        chk("sync_latency", lat, 3);

        // read-data wren steering
        for (int t = 0; t < 3; t++) begin
            ddr3_dpram_wren = 1'b1;
            #1;
            chk("wren_idle", ch_dpram_wren, 0);
            @(negedge clk);
        end
        ddr3_dpram_wren = 1'b0;
        exp_q.push_back(2'd1);
        req[1] = 1'b1;
        grant_phase(e, lat);
        cnt = 0;
        for (int t = 0; t < 8; t++) begin
            ddr3_dpram_wren = 1'b1;
            #1;
            chk("wren_steer", ch_dpram_wren, onehot(e));
            cnt += int'(ch_dpram_wren[1]);
            @(negedge clk);
        end
        ddr3_dpram_wren = 1'b0;
        #1;
        chk("wren_off", ch_dpram_wren, 0);
        chk("wren_pulses", cnt, 8);
        finish_phase(e, 1'b0);
        chk("no_timeout_yet", ack_timeout, 0);

        // reset while waiting for ack
        exp_q.push_back(2'd3);
        req = 4'b1000;
        grant_phase(e, lat);
        cyc(2);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_pg_req", ddr3_pg_req, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_grant", grant_idx, 0);
        req = 4'b1001;
        cyc(2);
        rst_n = 1'b1;
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd3);
        do_xfer(2, 1'b0, lat);
        do_xfer(2, 1'b0, lat);

        // ack timeout: withhold ack for 12 cycles
        chk("pre_timeout", ack_timeout, 0);
        exp_q.push_back(2'd2);
        req[2] = 1'b1;
        grant_phase(e, lat);
        cyc(9);
        chk("timeout_not_early", ack_timeout, 0);
        cyc(3);
        chk("timeout_set", ack_timeout, 1);
        chk("timeout_req_held", ddr3_pg_req, 1);
        chk("timeout_busy", busy, 1);
        finish_phase(e, 1'b0);
        chk("timeout_sticky", ack_timeout, 1);

        // fixed priority instance: ch1 and ch3 held, ch1 must win every time
        cnt = 0;
        fp_req = 4'b1010;
        for (int t = 0; t < 4; t++) begin
            exp_q.push_back(2'd1);
            e = exp_q.pop_front();
            lat = 0;
            while (fp_pg_req !== 1'b1 && lat < 50) begin
                @(negedge clk);
                lat++;
            end
            chk("fp_req_bound", fp_pg_req, 1);
            chk("fp_grant", fp_grant, e);
            chk("fp_addr", fp_addr, ch_addr[e]);
            if (fp_grant == 2'd3) cnt++;
            cyc(2);
            fp_ack = 1'b1;
            @(negedge clk);
            fp_ack = 1'b0;
            chk("fp_ch_ack", fp_ch_ack, onehot(e));
            fp_req[e] = 1'b0;
            lat = 0;
            while (fp_busy !== 1'b0 && lat < 50) begin
                @(negedge clk);
                lat++;
            end
            chk("fp_idle_bound", fp_busy, 0);
            if (t < 3) fp_req[e] = 1'b1;
            else fp_req = '0;
        end
        cyc(4);
        chk("fp_ch3_never", cnt, 0);
        chk("fp_final_idle", fp_busy, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
